minibyte_regdump_tx: RTL

//   Debug readback transmitter for the CPU register set: on request, snapshots A, B, PC, IR and CCR
//   and streams them out as a fixed 7-byte frame on a UART-style 8N1 serial line (LSB first).
//   It is the read side of the general/CCR/PC registers. It sits beside the core, observes only,
//   and never drives any register set/inc strobe.

---
 rtl/minibyte_pkg.sv | 18 +
 rtl/minibyte_baudgen.sv | 29 ++
 rtl/minibyte_regdump_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/minibyte_pkg.sv
// Shared definitions for the register-dump serial transmitter.
package minibyte_pkg;

    // Serial framing FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Bytes per dump frame: header, A, B, PC, IR, CCR, checksum
    localparam int          FRAME_LEN   = 7;
    localparam logic [2:0]  LAST_BYTE   = 3'(FRAME_LEN - 1);
    localparam logic [2:0]  LAST_BIT    = 3'd7;
    localparam logic [7:0]  HDR_DEFAULT = 8'hA5;

endpackage

// File: rtl/minibyte_baudgen.sv
// Bit-period tick generator: counts 0..CLKS_PER_BIT-1 while enabled, restarts when disabled.
module minibyte_baudgen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic en_in,
    output logic tick_out
);

    localparam int          CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Free-running bit counter, held at zero whenever the transmitter is idle
    always_ff @(posedge clk_in) begin
        if (!rst_in || !en_in) begin
            count <= '0;
        end else if (count == TERM) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick_out = en_in && (count == TERM);

endmodule

// File: rtl/minibyte_regdump_tx.sv
// Register snapshot dumper: streams HDR, A, B, PC, IR, CCR and an XOR checksum as 8N1 serial.
module minibyte_regdump_tx
    import minibyte_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 4,
    parameter logic [7:0] HDR_BYTE     = HDR_DEFAULT
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic [7:0] pc_in,
    input  logic [7:0] ir_in,
    input  logic [1:0] ccr_in,
    input  logic       dump_req_in,
    output logic       busy_out,
    output logic       done_out,
    output logic       tx_out
);

    state_t     state, state_n;
    logic [2:0] byte_idx, byte_idx_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic       tx_n, busy_n, done_n;
    logic       capture;
    logic       tick;
    logic [7:0] cur_byte;

    logic [7:0] snap_a, snap_b, snap_pc, snap_ir;
    logic [1:0] snap_ccr;
    logic [7:0] checksum;

    minibyte_baudgen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .en_in   (state != ST_IDLE),
        .tick_out(tick)
    );

    // Snapshot and checksum are frozen at the accepting edge so the frame is self-consistent
    always_ff @(posedge clk_in) begin
        if (capture) begin
            snap_a   <= a_in;
            snap_b   <= b_in;
            snap_pc  <= pc_in;
            snap_ir  <= ir_in;
            snap_ccr <= ccr_in;
            checksum <= HDR_BYTE ^ a_in ^ b_in ^ pc_in ^ ir_in ^ {6'b0, ccr_in};
        end
    end

    // Byte mux keyed on the upcoming byte index so tx can be registered without a bubble
    always_comb begin
        cur_byte = HDR_BYTE;
        case (byte_idx_n)
            3'd0:    cur_byte = HDR_BYTE;
            3'd1:    cur_byte = snap_a;
            3'd2:    cur_byte = snap_b;
            3'd3:    cur_byte = snap_pc;
            3'd4:    cur_byte = snap_ir;
            3'd5:    cur_byte = {6'b0, snap_ccr};
            default: cur_byte = checksum;
        endcase
    end

    // Next-state logic plus the next value of every registered output
    always_comb begin
        state_n    = state;
        byte_idx_n = byte_idx;
        bit_idx_n  = bit_idx;
        done_n     = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dump_req_in) begin
                    capture    = 1'b1;
                    byte_idx_n = 3'd0;
                    bit_idx_n  = 3'd0;
                    state_n    = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    bit_idx_n = 3'd0;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (byte_idx < LAST_BYTE) begin
                        byte_idx_n = byte_idx + 3'd1;
                        state_n    = ST_START;
                    end else begin
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n = (state_n != ST_IDLE);
        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = cur_byte[bit_idx_n];
            default:  tx_n = 1'b1;
        endcase
    end

    // State, indices and outputs; reset aborts any frame in flight
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state    <= ST_IDLE;
            byte_idx <= 3'd0;
            bit_idx  <= 3'd0;
            tx_out   <= 1'b1;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            state    <= state_n;
            byte_idx <= byte_idx_n;
            bit_idx  <= bit_idx_n;
            tx_out   <= tx_n;
            busy_out <= busy_n;
            done_out <= done_n;
        end
    end

endmodule
